// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file writeback arbiter.
package reg_wb_arbiter_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned CNT_W        = 3;
  localparam int unsigned STARVE_LIMIT = 4;

  localparam logic [0:0] A_PRIO  = 1'b0;
  localparam logic [0:0] B_FORCE = 1'b1;

  localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);

endpackage

// File: rtl/reg_wb_arbiter_starve_ctr.sv
// Starvation counter for requester B: saturates at the limit, clears, and freezes on hold.
module wb_starve_ctr
  import reg_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_freeze,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_limit_hit_c
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (!i_freeze) begin
      if (i_clear) begin
        w_count_nxt = '0;
      end else if (i_inc && (r_count != CNT_W'(STARVE_LIMIT))) begin
        w_count_nxt = r_count + CNT_W'(1);
      end
    end
  end

  // Flags the edge at which the count lands on the limit, so the FSM switches in step.
  assign o_limit_hit_c = (w_count_nxt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU (A) and the
// multi-cycle unit (B), with A priority and a starvation guard for B.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic              RegWrite_o,
  output logic              starve_o
);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_a_grant;
  logic              w_b_grant;
  logic              w_limit_hit;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_reg_write;

  // Grants depend only on valids, hold and state; reset masks them immediately.
  assign w_a_grant = rst_i && !hold_i && a_valid_i &&
                     ((r_state == A_PRIO) || !b_valid_i);
  assign w_b_grant = rst_i && !hold_i && b_valid_i &&
                     ((r_state == B_FORCE) || !a_valid_i);

  assign a_ready_o = w_a_grant;
  assign b_ready_o = w_b_grant;

  wb_starve_ctr u_ctr (
    .clk           (clk_i),
    .rst_n         (rst_i),
    .i_freeze      (hold_i),
    .i_clear       (w_b_grant || !b_valid_i),
    .i_inc         (b_valid_i && !w_b_grant),
    .o_limit_hit_c (w_limit_hit)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= A_PRIO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!hold_i) begin
      case (r_state)
        A_PRIO:  if (w_limit_hit) w_state_nxt = B_FORCE;
        B_FORCE: if (w_b_grant || !b_valid_i) w_state_nxt = A_PRIO;
        default: w_state_nxt = A_PRIO;
      endcase
    end
  end

  // Output stage: one-cycle latency, writes to register 0 are accepted but discarded.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
      r_reg_write <= 1'b0;
    end else if (w_a_grant) begin
      r_rd_addr   <= a_addr_i;
      r_rd_data   <= a_data_i;
      r_reg_write <= (a_addr_i != REG_ZERO);
    end else if (w_b_grant) begin
      r_rd_addr   <= b_addr_i;
      r_rd_data   <= b_data_i;
      r_reg_write <= (b_addr_i != REG_ZERO);
    end else begin
      r_reg_write <= 1'b0;
    end
  end

  assign RDaddr_o   = r_rd_addr;
  assign RDdata_o   = r_rd_data;
  assign RegWrite_o = r_reg_write;
  assign starve_o   = (r_state == B_FORCE);

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters.
- Requester A is the in-order ALU pipeline; requester B is the multi-cycle unit (mul/div/load).
- Grants one write per cycle with A priority, plus a starvation guard that forces a B grant.
- Drives registered RDaddr/RDdata/RegWrite to the register file; suppresses writes to register 0.

Parameters:
DATA_W  32  data width of a write
ADDR_W  5  register address width
STARVE_LIMIT  4  consecutive denied cycles of a valid B request before B is forced to win (1..2^CNT_W-1)
CNT_W  3  starvation counter width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset; one clock; reset is asynchronous and active-low
hold_i  input  1  controller stall; 1 = grant nothing this cycle
a_valid_i  input  1  A has a write pending
a_addr_i  input  ADDR_W  A destination register
a_data_i  input  DATA_W  A write data
a_ready_o  output  1  A write accepted this cycle (combinational)
b_valid_i  input  1  B has a write pending
b_addr_i  input  ADDR_W  B destination register
b_data_i  input  DATA_W  B write data
b_ready_o  output  1  B write accepted this cycle (combinational)
RDaddr_o  output  ADDR_W  register file write address
RDdata_o  output  DATA_W  register file write data
RegWrite_o  output  1  register file write enable
starve_o  output  1  FSM in B_FORCE state (status)

Behaviour:
- Reset (rst_i=0, async): RDaddr_o=0, RDdata_o=0, RegWrite_o=0, counter=0, FSM=A_PRIO, starve_o=0. a_ready_o/b_ready_o are 0 while rst_i=0.
- Handshake: a request transfers when valid & ready are both high at a rising edge. ready depends on valid, hold_i and FSM state only, never on data. Requesters hold addr/data stable until accepted.
- hold_i=1: both ready=0; RegWrite_o=0 the next cycle; counter frozen (neither incremented nor cleared); FSM unchanged.
- FSM A_PRIO, hold_i=0: A valid -> grant A; else B valid -> grant B; neither valid -> no grant.
- FSM B_FORCE, hold_i=0: B valid -> grant B; otherwise grant A if valid.
- Starvation counter, hold_i=0:
  - Increments when b_valid_i=1 and B is not granted.
  - Clears on a B grant or when b_valid_i=0.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - A_PRIO -> B_FORCE when the counter reaches STARVE_LIMIT at a clock edge. At STARVE_LIMIT=4, four denied cycles give a forced grant in the 5th.
  - B_FORCE -> A_PRIO on a B grant, or if b_valid_i drops (counter cleared).
- Output stage, 1-cycle latency: the cycle after a grant, RDaddr_o/RDdata_o = granted addr/data and RegWrite_o=1, except RegWrite_o=0 when the granted addr=0. A write to register 0 is still accepted (ready=1) and then discarded.
- No grant: RegWrite_o=0; RDaddr_o/RDdata_o hold their previous values.
- Ordering: at most one write per cycle. A and B targeting the same register in the same cycle: the winner writes first and the loser one or more cycles later, so the loser's value is final. Upstream issue logic owns WAW correctness; the arbiter never reorders within one requester.
- Reset mid-operation: an in-flight output write is dropped (RegWrite_o forced 0 immediately). No partial state survives.

Decomposition:
- Shared package: DATA_W/ADDR_W constants, FSM state encoding (A_PRIO=0, B_FORCE=1), REG_ZERO=0 constant.
- One natural sub-module, wb_starve_ctr: the counter with saturate, clear and freeze, exposing a limit_hit flag.
- Grant logic and the output register stay in the top.

Test Plan:
1. Reset then idle: rst_i=0 mid-cycle -> all outputs 0 immediately. Release with no valids -> RegWrite_o stays 0.
2. A only: a_valid=1, addr=5, data=0x1234 -> a_ready=1 same cycle. Next cycle RDaddr_o=5, RDdata_o=0x1234, RegWrite_o=1.
3. Contention, STARVE_LIMIT=4: A valid continuously (addr=3), B valid (addr=7, data=0xBEEF):
   - A granted for 4 cycles while the counter goes 1..4.
   - 5th cycle: b_ready=1 and starve_o=1.
   - Next cycle RDaddr_o=7 and FSM back in A_PRIO.
4. Register 0: B valid, addr=0, data=0xFFFF -> b_ready=1. Next cycle RegWrite_o=0. A following A write to addr=9 is unaffected.
5. hold_i: A and B valid with hold_i=1 for 3 cycles -> both ready=0, RegWrite_o=0, counter unchanged. After release, A is granted first.
6. Reset mid-write: grant A (addr=4), assert rst_i=0 before the next edge -> RegWrite_o=0 and the register-4 write is not performed.
